// File: rtl/fp_regfile_sb.sv
// FP register file with three bypassed read ports, two write ports, a per-register
// busy scoreboard for long-latency ops, and an FS-style dirty tracker.

module fp_regfile_sb_rdport #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int AW   = 5
) (
   input  logic [NREG-1:0][XLEN-1:0] regs,
   input  logic [NREG-1:0]           busy,
   input  logic                      wa_en,
   input  logic [AW-1:0]             wa_addr,
   input  logic [XLEN-1:0]           wa_data,
   input  logic                      wb_en,
   input  logic [AW-1:0]             wb_addr,
   input  logic [XLEN-1:0]           wb_data,
   input  logic                      iss_en,
   input  logic [AW-1:0]             iss_rd,
   input  logic [AW-1:0]             rs_addr,
   output logic [XLEN-1:0]           rs_data,
   output logic                      rs_busy
);
   localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

   logic valid, wa_hit, wb_hit, iss_hit;

   assign valid   = {1'b0, rs_addr} < NREG_W;
   assign wa_hit  = wa_en  && (wa_addr == rs_addr);
   assign wb_hit  = wb_en  && (wb_addr == rs_addr);
   assign iss_hit = iss_en && (iss_rd  == rs_addr);

   always_comb begin
      rs_data = '0;
      rs_busy = 1'b0;
      if (valid) begin
         if (wa_hit)      rs_data = wa_data;
         else if (wb_hit) rs_data = wb_data;
         else             rs_data = regs[rs_addr];
         // a same-cycle return hides busy, unless a new issue re-arms it
         rs_busy = busy[rs_addr] & ~(wb_hit & ~iss_hit);
      end
   end
endmodule

module fp_regfile_sb #(
   parameter int              XLEN    = 32,
   parameter int              NREG    = 32,
   parameter logic [XLEN-1:0] RST_VAL = '0,
   localparam int             AW      = $clog2(NREG)
) (
   input  logic            clock,
   input  logic            rstn,
   input  logic            wa_en,
   input  logic [AW-1:0]   wa_addr,
   input  logic [XLEN-1:0] wa_data,
   input  logic            wb_en,
   input  logic [AW-1:0]   wb_addr,
   input  logic [XLEN-1:0] wb_data,
   input  logic            iss_en,
   input  logic [AW-1:0]   iss_rd,
   input  logic            fs_clean,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   input  logic [AW-1:0]   rs3_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic [XLEN-1:0] rs3_data,
   output logic            rs1_busy,
   output logic            rs2_busy,
   output logic            rs3_busy,
   output logic            sb_idle,
   output logic [1:0]      fs_state
);
   localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

   typedef enum logic [1:0] {
      FS_OFF   = 2'b00,
      FS_INIT  = 2'b01,
      FS_CLEAN = 2'b10,
      FS_DIRTY = 2'b11
   } fs_e;

   logic [NREG-1:0][XLEN-1:0] regs;
   logic [NREG-1:0]           busy;
   logic [2:0][AW-1:0]        rs_addr;
   logic [2:0][XLEN-1:0]      rs_data;
   logic [2:0]                rs_busy;
   logic                      wa_ok, wb_ok, iss_ok;
   fs_e                       fs_q, fs_d;

   // out-of-range destinations are dropped entirely
   assign wa_ok  = wa_en  && ({1'b0, wa_addr} < NREG_W);
   assign wb_ok  = wb_en  && ({1'b0, wb_addr} < NREG_W);
   assign iss_ok = iss_en && ({1'b0, iss_rd}  < NREG_W);

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         regs <= {NREG{RST_VAL}};
         busy <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (wa_ok && wa_addr == AW'(i))      regs[i] <= wa_data;
            else if (wb_ok && wb_addr == AW'(i)) regs[i] <= wb_data;
            if (iss_ok && iss_rd == AW'(i))      busy[i] <= 1'b1;
            else if (wb_ok && wb_addr == AW'(i)) busy[i] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) fs_q <= FS_INIT;
      else       fs_q <= fs_d;
   end

   always_comb begin
      fs_d = fs_q;
      if (wa_ok || wb_ok) fs_d = FS_DIRTY;
      else if (fs_clean)  fs_d = FS_CLEAN;
   end

   assign fs_state = fs_q;
   assign sb_idle  = ~|busy;
   assign rs_addr  = {rs3_addr, rs2_addr, rs1_addr};

   for (genvar p = 0; p < 3; p++) begin : g_rd
      fp_regfile_sb_rdport #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_rd (
         .regs    (regs),
         .busy    (busy),
         .wa_en   (wa_en),
         .wa_addr (wa_addr),
         .wa_data (wa_data),
         .wb_en   (wb_en),
         .wb_addr (wb_addr),
         .wb_data (wb_data),
         .iss_en  (iss_en),
         .iss_rd  (iss_rd),
         .rs_addr (rs_addr[p]),
         .rs_data (rs_data[p]),
         .rs_busy (rs_busy[p])
      );
   end

   assign rs1_data = rs_data[0];
   assign rs2_data = rs_data[1];
   assign rs3_data = rs_data[2];
   assign rs1_busy = rs_busy[0];
   assign rs2_busy = rs_busy[1];
   assign rs3_busy = rs_busy[2];
endmodule
